// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle controller: states, opcodes, functs,
// mux/ALU select codes and the one-hot instruction class.
package mc_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXE    = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_ERR    = 3'd5
  } state_e;

  localparam logic [5:0] OP_RTYPE   = 6'b000000;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_LUI     = 6'b001111;
  localparam logic [5:0] OP_LW      = 6'b100011;
  localparam logic [5:0] OP_SW      = 6'b101011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] FUNCT_ADDU = 6'b100001;
  localparam logic [5:0] FUNCT_SUBU = 6'b100011;

  localparam logic [1:0] EXT_ZERO   = 2'b00;
  localparam logic [1:0] EXT_SIGN   = 2'b01;
  localparam logic [1:0] EXT_UPPER  = 2'b10;

  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_SUB    = 2'b01;
  localparam logic [1:0] ALU_OR     = 2'b10;

  localparam logic [1:0] NPC_PC4    = 2'b00;
  localparam logic [1:0] NPC_BRANCH = 2'b01;
  localparam logic [1:0] NPC_JUMP   = 2'b10;

  typedef struct packed {
    logic addu;
    logic subu;
    logic ori;
    logic lui;
    logic lw;
    logic sw;
    logic beq;
    logic j;
  } iclass_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational op/funct decoder producing a one-hot instruction class and
// a legal flag (any class bit set).
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output iclass_t    cls,
  output logic       legal
);

  always_comb begin
    cls = '0;
    case (op)
      OP_RTYPE: begin
        cls.addu = (funct == FUNCT_ADDU);
        cls.subu = (funct == FUNCT_SUBU);
      end
      OP_ORI:  cls.ori = 1'b1;
      OP_LUI:  cls.lui = 1'b1;
      OP_LW:   cls.lw  = 1'b1;
      OP_SW:   cls.sw  = 1'b1;
      OP_BEQ:  cls.beq = 1'b1;
      OP_J:    cls.j   = 1'b1;
      default: ;
    endcase
  end

  assign legal = |cls;

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS-subset controller FSM. Define MC_CTRL_ILLEGAL_TRAP_EN to
// trap unknown instructions in ERR; otherwise they retire as a NOP.
module mc_ctrl
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWr,
  output logic       IRWr,
  output logic       RegWr,
  output logic       MemWr,
  output logic [1:0] EXTOp,
  output logic [1:0] ALUOp,
  output logic [1:0] NPCOp,
  output logic       RegDst,
  output logic       WDSel,
  output logic       BSel,
  output logic [2:0] state,
  output logic       illegal
);

  state_e  state_q, state_d;
  iclass_t cls;
  logic    legal;
  logic    pc_wr, ir_wr, reg_wr, mem_wr;

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  localparam state_e ILLEGAL_NEXT = S_ERR;
  localparam state_e ERR_NEXT     = S_ERR;
`else
  localparam state_e ILLEGAL_NEXT = S_FETCH;
  localparam state_e ERR_NEXT     = S_FETCH;
`endif

  mc_decode u_decode (
    .op    (op),
    .funct (funct),
    .cls   (cls),
    .legal (legal)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        if (!legal)     state_d = ILLEGAL_NEXT;
        else if (cls.j) state_d = S_FETCH;
        else            state_d = S_EXE;
      end
      S_EXE: begin
        if (cls.beq)              state_d = S_FETCH;
        else if (cls.lw | cls.sw) state_d = S_MEM;
        else                      state_d = S_WB;
      end
      S_MEM: begin
        if (mem_ready) state_d = cls.lw ? S_WB : S_FETCH;
      end
      S_WB:     state_d = S_FETCH;
      S_ERR:    state_d = ERR_NEXT;
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;

  always_comb begin
    illegal_d = illegal_q | ((state_q == S_DECODE) & ~legal);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) illegal_q <= 1'b0;
    else       illegal_q <= illegal_d;
  end

  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  always_comb begin
    pc_wr  = 1'b0;
    ir_wr  = 1'b0;
    reg_wr = 1'b0;
    mem_wr = 1'b0;
    NPCOp  = NPC_PC4;
    case (state_q)
      S_FETCH: begin
        ir_wr = 1'b1;
        pc_wr = 1'b1;
      end
      S_DECODE: begin
        if (cls.j) begin
          pc_wr = 1'b1;
          NPCOp = NPC_JUMP;
        end
      end
      S_EXE: begin
        if (cls.beq) begin
          pc_wr = zero;
          NPCOp = NPC_BRANCH;
        end
      end
      S_MEM:   mem_wr = cls.sw;
      S_WB:    reg_wr = 1'b1;
      default: ;
    endcase
  end

  // Reset overrides every strobe, even the FETCH ones of the reset state.
  assign PCWr   = pc_wr  & ~reset;
  assign IRWr   = ir_wr  & ~reset;
  assign RegWr  = reg_wr & ~reset;
  assign MemWr  = mem_wr & ~reset;

  assign EXTOp  = cls.ori ? EXT_ZERO : (cls.lui ? EXT_UPPER : EXT_SIGN);
  assign ALUOp  = (cls.subu | cls.beq) ? ALU_SUB :
                  ((cls.ori | cls.lui) ? ALU_OR : ALU_ADD);
  assign BSel   = cls.ori | cls.lui | cls.lw | cls.sw;
  assign RegDst = cls.addu | cls.subu;
  assign WDSel  = cls.lw;
  assign state  = state_q;

endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 Ports SHALL be as listed, one per line: name, direction, width, meaning.
REQ-002 clk  in  1  single clock, rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 op  in  6  IR[31:26], stable from DECODE onward.
REQ-005 funct  in  6  IR[5:0].
REQ-006 zero  in  1  ALU equality flag.
REQ-007 mem_ready  in  1  data memory completes access this cycle.
REQ-008 PCWr, IRWr, RegWr, MemWr  out  1 each  write strobes.
REQ-009 EXTOp  out  2  00 zero-ext, 01 sign-ext, 10 upper (imm<<16).
REQ-010 ALUOp  out  2  00 add, 01 sub, 10 or.
REQ-011 NPCOp  out  2  00 PC+4, 01 branch, 10 jump.
REQ-012 RegDst  out  1  0 rt, 1 rd.
REQ-013 WDSel  out  1  0 ALU result, 1 memory data.
REQ-014 BSel  out  1  0 register rt, 1 imm32.
REQ-015 state  out  3  current FSM state, for debug.
REQ-016 illegal  out  1  sticky unknown-instruction flag.

Function
REQ-017 Supported instructions SHALL be addu and subu (op 000000, funct 100001/100011), ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, j 000010.
REQ-018 States SHALL be FETCH=0, DECODE=1, EXE=2, MEM=3, WB=4, ERR=5.
REQ-019 All outputs SHALL be Moore; they depend only on the registered state and the op/funct decode.
REQ-020 FETCH SHALL assert IRWr=1, PCWr=1, NPCOp=00, then go to DECODE unconditionally.
REQ-021 DECODE with j SHALL assert PCWr=1, NPCOp=10, then go to FETCH; any other legal opcode goes to EXE.
REQ-022 EXE with beq SHALL assert ALUOp=01, NPCOp=01, PCWr=zero, then go to FETCH.
REQ-023 EXE with lw/sw SHALL go to MEM; addu/subu/ori/lui SHALL go to WB.
REQ-024 MEM SHALL hold while mem_ready=0; for sw, MemWr=1 throughout MEM; on mem_ready=1, sw goes to FETCH and lw goes to WB.
REQ-025 WB SHALL assert RegWr=1 for exactly one cycle, then go to FETCH.
REQ-026 EXTOp SHALL be 00 for ori, 10 for lui, 01 otherwise.
REQ-027 BSel=1 for ori/lui/lw/sw; RegDst=1 only for R-type; WDSel=1 only for lw.
REQ-028 ALUOp SHALL be 01 for subu/beq, 10 for ori/lui, 00 otherwise.
REQ-029 Latency in cycles SHALL be: j 2, beq 3, R-type/ori/lui 4, sw 4+N, lw 5+N (N = mem_ready wait cycles).
REQ-030 Strobes not named for a state SHALL be 0 in that state.

Reset
REQ-031 Assertion of reset SHALL force state=FETCH and illegal=0 immediately, including mid-MEM.
REQ-032 While reset=1, all strobes SHALL be 0 regardless of state.
REQ-033 The first FETCH strobes SHALL appear in the first cycle after reset deasserts.

Configuration
REQ-034 Macro MC_CTRL_ILLEGAL_TRAP_EN SHALL control unknown-opcode handling.
REQ-035 With the macro defined, an unknown op/funct in DECODE SHALL go to ERR, set illegal=1, and remain there with all strobes 0 until reset.
REQ-036 Without the macro, an unknown op/funct in DECODE SHALL return to FETCH as a NOP, and illegal SHALL be tied to 0.

Structure
REQ-037 Shared package mc_pkg SHALL hold the state encodings, opcode/funct constants, and EXTOp/ALUOp/NPCOp codes.
REQ-038 Sub-module mc_decode SHALL map op/funct combinationally to a one-hot instruction class plus a legal flag.

Verification
REQ-039 ori in IR -> FETCH, DECODE, EXE, WB; EXTOp=00, BSel=1, ALUOp=10; RegWr=1 in cycle 4 only.
REQ-040 lw with mem_ready low for 2 cycles -> MEM held 3 cycles; WDSel=1; RegWr pulses once; 7 cycles total.
REQ-041 beq with zero=1 -> PCWr=1, NPCOp=01 in EXE; with zero=0 -> PCWr=0; next state FETCH in both cases.
REQ-042 reset asserted during MEM of sw -> MemWr drops in the same cycle; state=0; FETCH resumes after release.
REQ-043 op=111111 with the macro defined -> state=5, illegal=1 held until reset; without the macro -> back to FETCH, illegal=0.
REQ-044 lui then j -> EXTOp=10 during lui; j completes in 2 cycles with NPCOp=10.
